// File: rtl/parking_pkg.sv
// Shared types and constants for the parking day controller.
package parking_pkg;

  localparam int HOUR_W        = 4;
  localparam int DEF_MAX_HOURS = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DUMP = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/parking_hour_log.sv
// Hourly entry log: one CNT_W counter per work hour, write port plus
// combinational read port. Writes to hours >= MAX_HOURS fall through.
module parking_hour_log
  import parking_pkg::*;
#(
  parameter int MAX_HOURS = DEF_MAX_HOURS,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              we,
  input  logic [HOUR_W-1:0] wr_hour,
  input  logic [CNT_W-1:0]  wr_count,
  input  logic [HOUR_W-1:0] rd_hour,
  output logic [CNT_W-1:0]  rd_count
);

  logic [CNT_W-1:0] mem_r [MAX_HOURS];

  // Storage: cleared on reset and at the start of each day.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_HOURS; i++) mem_r[i] <= {CNT_W{1'b0}};
    end else if (clear) begin
      for (int i = 0; i < MAX_HOURS; i++) mem_r[i] <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < MAX_HOURS; i++) begin
        if (we && (wr_hour == HOUR_W'(i))) mem_r[i] <= wr_count;
      end
    end
  end

  // Read mux.
  always_comb begin
    rd_count = {CNT_W{1'b0}};
    for (int i = 0; i < MAX_HOURS; i++) begin
      if (rd_hour == HOUR_W'(i)) rd_count = mem_r[i];
    end
  end

endmodule

// File: rtl/parking_day_ctrl.sv
// Day-level parking controller: timer gating, capacity-checked entry,
// hourly entry logging and log dump. Optional rush-hour tracking: RUSH_TRACK_EN.
module parking_day_ctrl
  import parking_pkg::*;
#(
  parameter int LOT_SIZE  = 3,
  parameter int MAX_HOURS = DEF_MAX_HOURS,
  parameter int CNT_W     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_day,
  input  logic                          car_enter,
  input  logic                          car_exit,
  input  logic [3:0]                    work_hour,
  input  logic                          expired_one_hour,
  input  logic                          work_day_expired,
  output logic                          timer_hold,
  output logic [$clog2(LOT_SIZE+1)-1:0] occupancy,
  output logic                          lot_full,
  output logic                          entry_accept,
  output logic                          log_valid,
  input  logic                          log_ready,
  output logic [3:0]                    log_hour,
  output logic [CNT_W-1:0]              log_count,
  output logic                          busy
`ifdef RUSH_TRACK_EN
  ,
  output logic                          rush_valid,
  output logic [3:0]                    rush_hour
`endif
);

  localparam int OCC_W = $clog2(LOT_SIZE + 1);
  localparam logic [OCC_W-1:0]  LOT_MAX   = OCC_W'(LOT_SIZE);
  localparam logic [HOUR_W:0]   HOURS_LIM = (HOUR_W + 1)'(MAX_HOURS);

  state_t             state_r, next_state_s;
  logic               start_s, accept_s, exit_s, store_s, hour_end_s, xfer_s;
  logic               timer_hold_s, busy_s;
  logic [OCC_W-1:0]   occ_next_s;
  logic [CNT_W-1:0]   hour_cnt_r, store_val_s, rd_count_s;
  logic [HOUR_W:0]    n_entries_r, rd_ptr_r, wr_hour_ext_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != {CNT_W{1'b1}})) sat_inc = v + CNT_W'(1);
    else                             sat_inc = v;
  endfunction

  // Event qualification and next occupancy.
  always_comb begin
    start_s       = start_day && ((state_r == IDLE) || (state_r == DONE));
    accept_s      = car_enter && (state_r == RUN) && ((occupancy != LOT_MAX) || car_exit);
    exit_s        = car_exit && (occupancy != {OCC_W{1'b0}});
    hour_end_s    = expired_one_hour && (state_r == RUN);
    wr_hour_ext_s = {1'b0, work_hour};
    store_s       = hour_end_s && (wr_hour_ext_s < HOURS_LIM);
    store_val_s   = sat_inc(hour_cnt_r, accept_s);
    xfer_s        = log_valid && log_ready;
    if (accept_s && !exit_s)      occ_next_s = occupancy + OCC_W'(1);
    else if (exit_s && !accept_s) occ_next_s = occupancy - OCC_W'(1);
    else                          occ_next_s = occupancy;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= next_state_s;
  end

  // Next-state logic; DUMP exits on the last transfer or immediately when the log is empty.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: if (start_day) next_state_s = RUN;  else next_state_s = IDLE;
      RUN:  if (work_day_expired) next_state_s = DUMP; else next_state_s = RUN;
      DUMP: begin
        if ((xfer_s && ((rd_ptr_r + (HOUR_W + 1)'(1)) == n_entries_r)) ||
            (!log_valid && (rd_ptr_r >= n_entries_r)))
          next_state_s = DONE;
        else
          next_state_s = DUMP;
      end
      DONE: if (start_day) next_state_s = RUN;  else next_state_s = DONE;
      default: next_state_s = IDLE;
    endcase
  end

  // State outputs, decoded from the next state so the registered copy tracks state_r.
  always_comb begin
    timer_hold_s = 1'b1;
    busy_s       = 1'b0;
    case (next_state_s)
      RUN, DUMP: begin timer_hold_s = 1'b0; busy_s = 1'b1; end
      default:   begin timer_hold_s = 1'b1; busy_s = 1'b0; end
    endcase
  end

  // Registered state outputs, occupancy and entry pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_hold   <= 1'b1;
      busy         <= 1'b0;
      occupancy    <= {OCC_W{1'b0}};
      lot_full     <= 1'b0;
      entry_accept <= 1'b0;
    end else begin
      timer_hold   <= timer_hold_s;
      busy         <= busy_s;
      occupancy    <= occ_next_s;
      lot_full     <= (occ_next_s == LOT_MAX);
      entry_accept <= accept_s;
    end
  end

  // Hour counter and number of log entries to dump (highest stored hour + 1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hour_cnt_r  <= {CNT_W{1'b0}};
      n_entries_r <= {(HOUR_W + 1){1'b0}};
    end else if (start_s) begin
      hour_cnt_r  <= {CNT_W{1'b0}};
      n_entries_r <= {(HOUR_W + 1){1'b0}};
    end else begin
      if (hour_end_s) hour_cnt_r <= {CNT_W{1'b0}};
      else            hour_cnt_r <= sat_inc(hour_cnt_r, accept_s);
      if (store_s && (wr_hour_ext_s >= n_entries_r))
        n_entries_r <= wr_hour_ext_s + (HOUR_W + 1)'(1);
    end
  end

  parking_hour_log #(
    .MAX_HOURS (MAX_HOURS),
    .CNT_W     (CNT_W)
  ) u_log (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_s),
    .we       (store_s),
    .wr_hour  (work_hour),
    .wr_count (store_val_s),
    .rd_hour  (rd_ptr_r[HOUR_W-1:0]),
    .rd_count (rd_count_s)
  );

  // Dump streamer: present, hold until accepted, advance with a one-cycle bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r  <= {(HOUR_W + 1){1'b0}};
      log_valid <= 1'b0;
      log_hour  <= 4'd0;
      log_count <= {CNT_W{1'b0}};
    end else if (state_r != DUMP) begin
      rd_ptr_r  <= {(HOUR_W + 1){1'b0}};
      log_valid <= 1'b0;
    end else if (xfer_s) begin
      log_valid <= 1'b0;
      rd_ptr_r  <= rd_ptr_r + (HOUR_W + 1)'(1);
    end else if (!log_valid && (rd_ptr_r < n_entries_r)) begin
      log_valid <= 1'b1;
      log_hour  <= rd_ptr_r[HOUR_W-1:0];
      log_count <= rd_count_s;
    end
  end

`ifdef RUSH_TRACK_EN
  // First hour of the day in which the lot filled up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rush_valid <= 1'b0;
      rush_hour  <= 4'd0;
    end else if (start_s) begin
      rush_valid <= 1'b0;
      rush_hour  <= 4'd0;
    end else if ((state_r == RUN) && !rush_valid && !lot_full && (occ_next_s == LOT_MAX)) begin
      rush_valid <= 1'b1;
      rush_hour  <= work_hour;
    end
  end
`endif

endmodule
